// File: rtl/dot_channel_seq.sv
// dot_channel_seq: walks every (cs, phase) pair, fetching the window, running
// the dot_channel until valid, handing the result downstream, then clearing.
`default_nettype none

module dot_channel_seq #(
  parameter int CS_NUM    = 16,
  parameter int PHASE_NUM = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       d_req,
  input  logic       d_ack,
  output logic       ws_load,
  output logic       dc_load,
  output logic [3:0] cs,
  output logic [2:0] phase,
  input  logic       ch_valid,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_cs,
  output logic [2:0] res_phase,
  output logic       err
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [3:0]      CS_LAST = 4'(CS_NUM - 1);
  localparam logic [2:0]      PH_LAST = 3'(PHASE_NUM - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RUN   = 3'd2,
    S_EMIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wd        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      d_req     <= 1'b0;
      ws_load   <= 1'b0;
      dc_load   <= 1'b0;
      cs        <= '0;
      phase     <= '0;
      res_valid <= 1'b0;
      res_cs    <= '0;
      res_phase <= '0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            cs    <= '0;
            phase <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            d_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (d_ack) begin
            state   <= S_RUN;
            d_req   <= 1'b0;
            ws_load <= 1'b1;
            dc_load <= 1'b1;
            wd      <= '0;
          end
        end
        S_RUN: begin
          // A valid arriving on the expiry cycle still counts as a result.
          if (ch_valid) begin
            state     <= S_EMIT;
            res_valid <= 1'b1;
            res_cs    <= cs;
            res_phase <= phase;
          end else if (wd == WD_LAST) begin
            state   <= S_GAP;
            err     <= 1'b1;
            ws_load <= 1'b0;
            dc_load <= 1'b0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            state     <= S_GAP;
            res_valid <= 1'b0;
            ws_load   <= 1'b0;
            dc_load   <= 1'b0;
          end
        end
        S_GAP: begin
          // Counters stay on the final pair rather than wrapping past the sweep.
          if (cs == CS_LAST && phase == PH_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_FETCH;
            d_req <= 1'b1;
            if (phase == PH_LAST) begin
              phase <= '0;
              cs    <= cs + 1'b1;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dot_channel_seq.sv
// Randomized bench for dot_channel_seq: a channel/window/writer model drives the
// DUT while a monitor checks results and sequencing against expected queues.
`default_nettype none

module tb_dot_channel_seq;
  localparam int CS_NUM = 2, PHASE_NUM = 2, TIMEOUT = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start_main = 1'b0, start_noise = 1'b0;
  logic d_ack = 1'b0, ch_valid = 1'b0, res_ready = 1'b0;
  logic busy, done, d_req, ws_load, dc_load, res_valid, err;
  logic [3:0] cs, res_cs;
  logic [2:0] phase, res_phase;
  wire start = start_main | start_noise;

  always #5 clk = ~clk;

  dot_channel_seq #(.CS_NUM(CS_NUM), .PHASE_NUM(PHASE_NUM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .d_req(d_req), .d_ack(d_ack), .ws_load(ws_load), .dc_load(dc_load),
    .cs(cs), .phase(phase), .ch_valid(ch_valid), .res_valid(res_valid),
    .res_ready(res_ready), .res_cs(res_cs), .res_phase(res_phase), .err(err)
  );

  int total = 0, bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Environment knobs
  int stall_cs = -1, stall_ph = -1;
  int hold_cs = -1, hold_ph = -1, hold_cnt = 0;
  int dack_max = 0, ready_pct = 100;
  bit noise = 1'b0;

  // Channel, window buffer and writer models
  int ch_cnt = 0, ch_lat = 6, dq_cnt = 0, dq_delay = 0;
  always @(negedge clk) begin
    if (ws_load && dc_load) begin
      ch_cnt++;
      ch_valid = !(int'(cs) == stall_cs && int'(phase) == stall_ph) && (ch_cnt >= ch_lat);
    end else begin
      ch_cnt   = 0;
      ch_lat   = noise ? int'($urandom_range(1, 8)) : 6;
      ch_valid = noise && ($urandom % 4 == 0);
    end
    if (d_req) begin
      dq_cnt++;
      d_ack = (dq_cnt > dq_delay);
    end else begin
      dq_cnt   = 0;
      dq_delay = $urandom_range(0, dack_max);
      d_ack    = noise && ($urandom % 3 == 0);
    end
    if (res_valid) begin
      if (int'(res_cs) == hold_cs && int'(res_phase) == hold_ph && hold_cnt < 5) begin
        res_ready = 1'b0;
        hold_cnt++;
      end else begin
        res_ready = ($urandom % 100) < ready_pct;
      end
    end else begin
      res_ready = noise && ($urandom % 2 == 0);
    end
    start_noise = noise && busy && !done && ($urandom % 16 == 0);
  end

  // Scoreboard queues filled at start; the monitor drains them
  logic [6:0] exp_res[$];
  logic [6:0] exp_run[$];
  int  done_cnt = 0;
  bit  mon_en = 1'b0;

  initial begin
    bit         p_loads, p_rv, p_acc, p_dack, gap_pend, cur_stall;
    logic [6:0] p_tag, run_tag, got;
    int         run_len, dreq_cnt, cur_delay;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        p_loads = 0; p_rv = 0; p_acc = 0; p_dack = 0; gap_pend = 0;
        run_len = 0; dreq_cnt = 0; cur_stall = 0;
        continue;
      end
      if (done) done_cnt++;
      if (d_req) begin
        dreq_cnt++;
        cur_delay = dq_delay;
      end
      if (res_valid && p_rv && !p_acc) begin
        check("res_hold_stable", {25'd0, res_cs, res_phase}, {25'd0, p_tag});
        check("res_hold_loads", {31'd0, ws_load & dc_load}, 1);
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) check("res_unexpected", {25'd0, res_cs, res_phase}, 32'hFFFF);
        else begin
          got = exp_res.pop_front();
          check("res_tag", {25'd0, res_cs, res_phase}, {25'd0, got});
        end
      end
      if (gap_pend) begin
        check("gap_one_cycle", {31'd0, d_req | done}, 1);
        gap_pend = 0;
      end
      if (ws_load && !p_loads) begin
        check("run_after_ack", {31'd0, p_dack}, 1);
        check("dreq_cycles", dreq_cnt, cur_delay + 1);
        dreq_cnt = 0;
        run_tag  = {cs, phase};
        if (exp_run.size() == 0) check("run_unexpected", {25'd0, cs, phase}, 32'hFFFF);
        else begin
          got = exp_run.pop_front();
          check("run_pair", {25'd0, cs, phase}, {25'd0, got});
        end
        cur_stall = (int'(cs) == stall_cs && int'(phase) == stall_ph);
        run_len = 0;
      end
      if (ws_load) begin
        run_len++;
        if ({cs, phase} != run_tag) check("pair_held", {25'd0, cs, phase}, {25'd0, run_tag});
      end
      if (!ws_load && p_loads) begin
        check("gap_state", {30'd0, d_req, res_valid}, 0);
        if (cur_stall) begin
          check("timeout_len", run_len, TIMEOUT);
          check("timeout_err", {31'd0, err}, 1);
        end
        gap_pend = 1;
      end
      if (ws_load !== dc_load) check("loads_equal", {31'd0, dc_load}, {31'd0, ws_load});
      p_loads = ws_load;
      p_acc   = res_valid && res_ready;
      p_rv    = res_valid;
      p_tag   = {res_cs, res_phase};
      p_dack  = d_ack;
    end
  end

  task automatic push_expect();
    exp_res.delete();
    exp_run.delete();
    for (int c = 0; c < CS_NUM; c++)
      for (int p = 0; p < PHASE_NUM; p++) begin
        exp_run.push_back({4'(c), 3'(p)});
        if (!(c == stall_cs && p == stall_ph)) exp_res.push_back({4'(c), 3'(p)});
      end
  endtask

  task automatic kick();
    done_cnt = 0;
    hold_cnt = 0;
    push_expect();
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    #2;
    check("start_busy", {31'd0, busy}, 1);
    check("start_err_clear", {31'd0, err}, 0);
  endtask

  task automatic sweep(input bit exp_err);
    int n;
    kick();
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #2;
    check("done_once", done_cnt, 1);
    check("idle_busy", {31'd0, busy}, 0);
    check("res_left", exp_res.size(), 0);
    check("run_left", exp_run.size(), 0);
    check("sweep_err", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {12'd0, busy, done, d_req, ws_load, dc_load, cs, phase,
                            res_valid, res_cs, res_phase, err}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Zero-wait environment, fixed channel latency
    sweep(1'b0);

    // Backpressure on (0,1), delayed d_ack, noise and restart attempts
    noise = 1'b1; dack_max = 3; ready_pct = 50;
    hold_cs = 0; hold_ph = 1;
    sweep(1'b0);
    check("hold_applied", hold_cnt, 5);
    hold_cs = -1; hold_ph = -1;

    // Channel never valid on (1,0)
    stall_cs = 1; stall_ph = 0;
    sweep(1'b1);
    stall_cs = -1; stall_ph = -1;
    sweep(1'b0);

    // Asynchronous reset while running (1,1)
    kick();
    n = 0;
    while (!(ws_load && cs == 4'd1 && phase == 3'd1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("reach_11_timeout", 0, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset", {12'd0, busy, done, d_req, ws_load, dc_load, cs, phase,
                           res_valid, res_cs, res_phase, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("no_done_after_reset", {30'd0, done, busy}, 0);
    mon_en = 1'b1;
    @(negedge clk);
    sweep(1'b0);

    // Random sweeps with a random stalled pair
    for (int k = 0; k < 6; k++) begin
      if ($urandom % 2 == 0) begin
        stall_cs = $urandom_range(0, CS_NUM - 1);
        stall_ph = $urandom_range(0, PHASE_NUM - 1);
      end else begin
        stall_cs = -1; stall_ph = -1;
      end
      sweep(stall_cs >= 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
